dot_channel_seq: RTL and testbench

//   Tile scheduler for one dot channel (weight store + 36-wide inner product).

---
 rtl/dot_channel_seq.sv | 185 ++++++++++++++++++
 tb/tb_dot_channel_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_channel_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dot_channel_seq : tile scheduler for one dot channel (weight fetch, data
// handshake, accumulate window, indexed result strobe).  Rev 1.0
// ---------------------------------------------------------------------------
module dot_channel_seq #(
  parameter int NUM_CS    = 4,
  parameter int NUM_PHASE = 8,
  parameter int WS_LAT    = 2,
  parameter int ACC_MAX   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       d_rdy_i,
  input  logic       dc_valid_i,
  output logic       ws_load_o,
  output logic       dc_load_o,
  output logic [3:0] cs_o,
  output logic [2:0] phase_o,
  output logic       d_req_o,
  output logic       out_we_o,
  output logic [6:0] out_idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CNT_MAX = (WS_LAT > ACC_MAX) ? WS_LAT : ACC_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_WAITD = 3'd2,
    S_ACCUM = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cs_q, cs_d;
  logic [2:0]       phase_q, phase_d;
  logic [6:0]       idx_q, idx_d;
  logic             err_q, err_d;

  logic             ws_load_q, dc_load_q, d_req_q, out_we_q, busy_q, done_q;

  logic             w_last_phase;
  logic             w_last_tile;
  logic [6:0]       w_tile_idx;

  assign w_last_phase = (phase_q == 3'(NUM_PHASE - 1));
  assign w_last_tile  = w_last_phase && (cs_q == 4'(NUM_CS - 1));
  assign w_tile_idx   = 7'(cs_q) * 7'(NUM_PHASE) + 7'(phase_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cs_q    <= '0;
      phase_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WLOAD;
          cnt_d   = CNT_W'(1);
          cs_d    = '0;
          phase_d = '0;
          err_d   = 1'b0;
        end
      end
      S_WLOAD: begin
        if (cnt_q == CNT_W'(WS_LAT)) begin
          state_d = S_WAITD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAITD: begin
        if (d_rdy_i) begin
          state_d = S_ACCUM;
          cnt_d   = CNT_W'(1);
        end
      end
      S_ACCUM: begin
        // A result arriving on the final allowed cycle still wins over timeout.
        if (dc_valid_i) begin
          state_d = S_GAP;
          idx_d   = w_tile_idx;
        end else if (cnt_q == CNT_W'(ACC_MAX)) begin
          state_d = S_FIN;
          err_d   = 1'b1;
          cs_d    = '0;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (w_last_tile) begin
          state_d = S_FIN;
          cs_d    = '0;
          phase_d = '0;
        end else begin
          state_d = S_WLOAD;
          cnt_d   = CNT_W'(1);
          if (w_last_phase) begin
            phase_d = '0;
            cs_d    = cs_q + 4'd1;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cs_d    = '0;
      phase_d = '0;
      err_d   = err_q;
    end
  end

  // Strobes are decoded from the next state so every output comes from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_load_q <= 1'b0;
      dc_load_q <= 1'b0;
      d_req_q   <= 1'b0;
      out_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ws_load_q <= (state_d == S_WLOAD) || (state_d == S_WAITD) || (state_d == S_ACCUM);
      dc_load_q <= (state_d == S_ACCUM);
      d_req_q   <= (state_d == S_WAITD);
      out_we_q  <= (state_d == S_GAP);
      busy_q    <= (state_d == S_WLOAD) || (state_d == S_WAITD) ||
                   (state_d == S_ACCUM) || (state_d == S_GAP);
      done_q    <= (state_d == S_FIN);
    end
  end

  assign ws_load_o = ws_load_q;
  assign dc_load_o = dc_load_q;
  assign d_req_o   = d_req_q;
  assign out_we_o  = out_we_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign cs_o      = cs_q;
  assign phase_o   = phase_q;
  assign out_idx_o = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_channel_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dot_channel_seq : scoreboard bench for dot_channel_seq (2 cs x 2 phase).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dot_channel_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       d_rdy_i = 1'b1;
  logic       dc_valid_i = 1'b0;
  logic       ws_load_o, dc_load_o, d_req_o, out_we_o, busy_o, done_o, err_o;
  logic [3:0] cs_o;
  logic [2:0] phase_o;
  logic [6:0] out_idx_o;

  always #5 clk = ~clk;

  dot_channel_seq #(
    .NUM_CS(2), .NUM_PHASE(2), .WS_LAT(2), .ACC_MAX(10)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .d_rdy_i(d_rdy_i), .dc_valid_i(dc_valid_i),
    .ws_load_o(ws_load_o), .dc_load_o(dc_load_o), .cs_o(cs_o),
    .phase_o(phase_o), .d_req_o(d_req_o), .out_we_o(out_we_o),
    .out_idx_o(out_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic       is_done;
    logic [6:0] idx;
    logic       err;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_we(input int i);
    exp_q.push_back('{1'b0, 7'(i), 1'b0});
  endtask

  task automatic push_done(input logic e);
    exp_q.push_back('{1'b1, 7'd0, e});
  endtask

  // Monitor: pops one expected event per out_we / done strobe
  always @(negedge clk) begin
    if (out_we_o) begin
      if (exp_q.size() == 0) check("unexpected out_we", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("out_we in expected order", int'(!mon_e.is_done), 1);
        check("out_idx", int'(out_idx_o), int'(mon_e.idx));
      end
    end
    if (done_o) begin
      if (exp_q.size() == 0) check("unexpected done", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("done in expected order", int'(mon_e.is_done), 1);
        check("err at done", int'(err_o), int'(mon_e.err));
      end
    end
  end

  // Upstream/channel responder
  int dcv_at = 6;
  int no_dcv_tile = -1;
  int stall_tile = -1;
  int stall_left = 0;
  int run = 0;
  int last_run = 0;
  int r_tile;

  always @(negedge clk) begin
    r_tile = int'(cs_o) * 2 + int'(phase_o);
    if (dc_load_o) run = run + 1;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    dc_valid_i = dc_load_o && (run == dcv_at) && (r_tile != no_dcv_tile);
    if (d_req_o && (r_tile == stall_tile) && (stall_left > 0)) begin
      d_rdy_i = 1'b0;
      stall_left = stall_left - 1;
      check("stall ws_load", int'(ws_load_o), 1);
      check("stall dc_load", int'(dc_load_o), 0);
      check("stall out_we", int'(out_we_o), 0);
    end else begin
      d_rdy_i = 1'b1;
    end
  end

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(done_o), 1);
  endtask

  task automatic push_full_sweep();
    for (int i = 0; i < 4; i++) push_we(i);
    push_done(1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset ws_load", int'(ws_load_o), 0);
    check("reset dc_load", int'(dc_load_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset done", int'(done_o), 0);
    check("reset err", int'(err_o), 0);
    check("reset d_req", int'(d_req_o), 0);
    check("reset cs/phase", int'({cs_o, phase_o}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: plain sweep, result 6 cycles into each accumulate window
    push_full_sweep();
    do_start();
    n = 1;
    while (!out_we_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first out_we latency", n, 10);
    wait_done(200, "t1 done");
    check("t1 err", int'(err_o), 0);
    @(negedge clk);
    check("t1 busy after", int'(busy_o), 0);
    check("t1 drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // 2: upstream stall of 5 cycles on tile 1
    stall_tile = 1;
    stall_left = 5;
    push_full_sweep();
    do_start();
    wait_done(200, "t2 done");
    check("t2 stall consumed", stall_left, 0);
    stall_tile = -1;
    @(negedge clk);
    check("t2 drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // 3: accumulate timeout on tile 0
    no_dcv_tile = 0;
    push_done(1'b1);
    do_start();
    wait_done(100, "t3 done");
    @(negedge clk);
    no_dcv_tile = -1;
    check("t3 dc_load cycles", last_run, 10);
    check("t3 err held", int'(err_o), 1);
    check("t3 busy", int'(busy_o), 0);
    check("t3 drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // 4: abort during accumulate of tile 2, then restart
    push_we(0);
    push_we(1);
    do_start();
    n = 0;
    while (!(dc_load_o && cs_o == 4'd1 && phase_o == 3'd0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4 reached tile 2", int'(dc_load_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t4 busy after abort", int'(busy_o), 0);
    check("t4 dc_load after abort", int'(dc_load_o), 0);
    check("t4 ws_load after abort", int'(ws_load_o), 0);
    check("t4 err after abort", int'(err_o), 0);
    repeat (20) @(negedge clk);
    check("t4 drained", exp_q.size(), 0);
    push_full_sweep();
    do_start();
    wait_done(200, "t4 restart done");
    @(negedge clk);
    check("t4 restart drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // 5: start re-pulsed during weight load
    push_full_sweep();
    do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(200, "t5 done");
    repeat (5) @(negedge clk);
    check("t5 no second sweep", int'(busy_o), 0);
    check("t5 drained", exp_q.size(), 0);

    // 6: after an error sweep, reset in GAP of the next sweep
    no_dcv_tile = 0;
    push_done(1'b1);
    do_start();
    wait_done(100, "t6 err sweep done");
    @(negedge clk);
    no_dcv_tile = -1;
    check("t6 err before restart", int'(err_o), 1);
    push_we(0);
    do_start();
    check("t6 err cleared by start", int'(err_o), 0);
    n = 0;
    while (!out_we_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6 reached gap", int'(out_we_o), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6 out_we after rst", int'(out_we_o), 0);
    check("t6 err after rst", int'(err_o), 0);
    check("t6 busy after rst", int'(busy_o), 0);
    check("t6 strobes after rst", int'({ws_load_o, dc_load_o, d_req_o, done_o}), 0);
    check("t6 cs/phase/idx after rst", int'({cs_o, phase_o, out_idx_o}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
